// File: rtl/mux_bus_arbiter.sv
// Round-robin owner arbiter for the shared 16-bit 8:1 read-bus mux.
// Grants one requester at a time and enforces a hold limit and one turnaround cycle.
module mux_bus_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] REQ,
    output logic [2:0] SEL,
    output logic [7:0] GNT,
    output logic       BUS_VALID,
    output logic       TIMEOUT
);

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_e           r_state;
    logic [2:0]       r_sel;
    logic [7:0]       r_gnt;
    logic             r_valid;
    logic             r_timeout;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_last;

    logic             w_any;
    logic [2:0]       w_winner;
    logic             w_own_req;
    logic             w_hold_ok;
    logic [CNT_W-1:0] w_cnt_inc;

    // Search starts one past the last grantee so the most recent owner ranks lowest.
    always_comb begin
        logic [2:0] v_idx;
        w_any    = 1'b0;
        w_winner = r_last;
        v_idx    = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            v_idx = r_last + 3'(k);
            if (!w_any && REQ[v_idx]) begin
                w_any    = 1'b1;
                w_winner = v_idx;
            end
        end
    end

    assign w_own_req = REQ[r_sel];
    assign w_hold_ok = (MAX_HOLD == 0) || (r_cnt < HOLD_LIM);
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= StIdle;
            r_sel     <= 3'd0;
            r_gnt     <= 8'h00;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
            r_last    <= 3'd7;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_timeout <= 1'b0;
                    if (w_any) begin
                        r_gnt   <= 8'b1 << w_winner;
                        r_sel   <= w_winner;
                        r_valid <= 1'b1;
                        r_cnt   <= CNT_ONE;
                        r_last  <= w_winner;
                        r_state <= StBusy;
                    end
                end
                StBusy: begin
                    if (!w_own_req) begin
                        r_gnt     <= 8'h00;
                        r_valid   <= 1'b0;
                        r_timeout <= 1'b0;
                        r_state   <= StIdle;
                    end else if (w_hold_ok) begin
                        r_cnt     <= w_cnt_inc;
                        r_timeout <= 1'b0;
                    end else begin
                        // Forced release: owner still requests but used its full hold budget.
                        r_gnt     <= 8'h00;
                        r_valid   <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= StIdle;
                    end
                end
                default: begin
                    r_gnt     <= 8'h00;
                    r_valid   <= 1'b0;
                    r_timeout <= 1'b0;
                    r_state   <= StIdle;
                end
            endcase
        end
    end

    assign SEL       = r_sel;
    assign GNT       = r_gnt;
    assign BUS_VALID = r_valid;
    assign TIMEOUT   = r_timeout;

    a_gnt_onehot : assert property (@(posedge CLK) disable iff (RST) $onehot0(GNT));
    a_valid_eq   : assert property (@(posedge CLK) disable iff (RST) BUS_VALID == (|GNT));
    a_sel_match  : assert property (@(posedge CLK) disable iff (RST) BUS_VALID |-> GNT[SEL]);
    a_tout_idle  : assert property (@(posedge CLK) disable iff (RST) TIMEOUT |-> !BUS_VALID);

endmodule
